// File: rtl/alu_seq_if.sv
// alu_seq_if: bundle of the instruction-in handshake, the ALU drive/return path
// and the response-out handshake for alu_op_sequencer.
//   slave  : the sequencer's view (accepts instructions, drives the ALU, returns responses)
//   master : the environment's view (decode stage, ALU and writeback together)
interface alu_seq_if #(
    parameter int BITSIZE = 64
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instr;
    logic [BITSIZE-1:0] rn_data;
    logic [BITSIZE-1:0] rm_data;
    logic [2:0]         alu_opcode;
    logic [BITSIZE-1:0] alu_data1;
    logic [BITSIZE-1:0] alu_data2;
    logic [BITSIZE-1:0] alu_result;
    logic               alu_zero;
    logic               out_valid;
    logic               out_ready;
    logic [BITSIZE-1:0] out_result;
    logic [4:0]         out_rd;
    logic               out_wr_en;
    logic               out_z;
    logic               out_err;

    modport slave (
        input  in_valid, instr, rn_data, rm_data, alu_result, alu_zero, out_ready,
        output in_ready, alu_opcode, alu_data1, alu_data2,
               out_valid, out_result, out_rd, out_wr_en, out_z, out_err
    );

    modport master (
        output in_valid, instr, rn_data, rm_data, alu_result, alu_zero, out_ready,
        input  in_ready, alu_opcode, alu_data1, alu_data2,
               out_valid, out_result, out_rd, out_wr_en, out_z, out_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one LEGv8 instruction plus operands, decodes it to the
// 3-bit ALU opcode, drives the external combinational ALU for one cycle, captures
// result and zero flag, and holds a registered response until it is taken.
// FSM: IDLE -> EXEC (legal) / DONE (illegal) ; EXEC -> DONE ; DONE -(out_ready)-> IDLE.
// Optional build macro ALU_SEQ_STATS_EN adds response counters stat_ops / stat_illegal.
module alu_op_sequencer #(
    parameter int BITSIZE = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    alu_seq_if.slave    bus
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [31:0] stat_ops,
    output logic [31:0] stat_illegal
`endif
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_MOVA = 3'b011;
    localparam logic [2:0] OP_MOVB = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_MOVK = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic               legal;
        logic [2:0]         op;
        logic [BITSIZE-1:0] d1;
        logic [BITSIZE-1:0] d2;
        logic               wr_en;
    } dec_t;

    // Instruction decode; first matching pattern wins. rd=XZR never writes back.
    function automatic dec_t decode(input logic [31:0]        ins,
                                    input logic [BITSIZE-1:0] rn,
                                    input logic [BITSIZE-1:0] rm);
        dec_t d;
        d.legal = 1'b1;
        d.op    = OP_MOVA;
        d.d1    = rn;
        d.d2    = rm;
        d.wr_en = 1'b1;
        if (ins[31:21] == 11'b10001010000) begin
            d.op = OP_AND;
        end else if (ins[31:21] == 11'b10101010000) begin
            d.op = OP_OR;
        end else if (ins[31:21] == 11'b10001011000) begin
            d.op = OP_ADD;
        end else if (ins[31:21] == 11'b11001011000) begin
            d.op = OP_SUB;
        end else if (ins[31:22] == 10'b1001000100) begin
            d.op = OP_ADD;
            d.d2 = {{(BITSIZE-12){1'b0}}, ins[21:10]};
        end else if (ins[31:22] == 10'b1101000100) begin
            d.op = OP_SUB;
            d.d2 = {{(BITSIZE-12){1'b0}}, ins[21:10]};
        end else if (ins[31:23] == 9'b110100101) begin
            // MOVZ: only the hw=0 (lowest halfword) form is supported
            d.op    = OP_MOVB;
            d.d2    = {{(BITSIZE-16){1'b0}}, ins[20:5]};
            d.legal = (ins[22:21] == 2'b00);
        end else if (ins[31:23] == 9'b111100101) begin
            // MOVK: ALU keeps data1[BITSIZE-1:16] and inserts data2[15:0]
            d.op    = OP_MOVK;
            d.d2    = {{(BITSIZE-16){1'b0}}, ins[20:5]};
            d.legal = (ins[22:21] == 2'b00);
        end else if (ins[31:24] == 8'b10110100) begin
            // CBZ: pass Rt through so the branch unit can use out_z
            d.op    = OP_MOVA;
            d.d2    = {BITSIZE{1'b0}};
            d.wr_en = 1'b0;
        end else begin
            d.legal = 1'b0;
        end
        if (ins[4:0] == 5'd31) begin
            d.wr_en = 1'b0;
        end else begin
            d.wr_en = d.wr_en & d.legal;
        end
        if (!d.legal) begin
            d.wr_en = 1'b0;
        end else begin
            d.wr_en = d.wr_en;
        end
        return d;
    endfunction

    state_t             state_q,    state_d;
    logic               in_ready_q, in_ready_d;
    logic [2:0]         opcode_q,   opcode_d;
    logic [BITSIZE-1:0] data1_q,    data1_d;
    logic [BITSIZE-1:0] data2_q,    data2_d;
    logic               wr_pend_q,  wr_pend_d;
    logic [4:0]         rd_q,       rd_d;
    logic               valid_q,    valid_d;
    logic [BITSIZE-1:0] result_q,   result_d;
    logic               wr_en_q,    wr_en_d;
    logic               z_q,        z_d;
    logic               err_q,      err_d;
    dec_t               dec_s;

    assign dec_s = decode(bus.instr, bus.rn_data, bus.rm_data);

    // Next-state and next-register computation for the sequencer FSM.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        wr_pend_d = wr_pend_q;
        rd_d      = rd_q;
        valid_d   = valid_q;
        result_d  = result_q;
        wr_en_d   = wr_en_q;
        z_d       = z_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    rd_d = bus.instr[4:0];
                    if (dec_s.legal) begin
                        state_d   = S_EXEC;
                        opcode_d  = dec_s.op;
                        data1_d   = dec_s.d1;
                        data2_d   = dec_s.d2;
                        wr_pend_d = dec_s.wr_en;
                    end else begin
                        // illegal: skip the ALU and answer with an error response
                        state_d  = S_DONE;
                        valid_d  = 1'b1;
                        err_d    = 1'b1;
                        wr_en_d  = 1'b0;
                        z_d      = 1'b0;
                        result_d = {BITSIZE{1'b0}};
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                // ALU is combinational on the registered operands; capture now
                state_d  = S_DONE;
                valid_d  = 1'b1;
                err_d    = 1'b0;
                result_d = bus.alu_result;
                z_d      = ~bus.alu_zero;
                wr_en_d  = wr_pend_q;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            opcode_q   <= OP_MOVA;
            data1_q    <= {BITSIZE{1'b0}};
            data2_q    <= {BITSIZE{1'b0}};
            wr_pend_q  <= 1'b0;
            rd_q       <= 5'd0;
            valid_q    <= 1'b0;
            result_q   <= {BITSIZE{1'b0}};
            wr_en_q    <= 1'b0;
            z_q        <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            opcode_q   <= opcode_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            wr_pend_q  <= wr_pend_d;
            rd_q       <= rd_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            wr_en_q    <= wr_en_d;
            z_q        <= z_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.alu_opcode = opcode_q;
    assign bus.alu_data1  = data1_q;
    assign bus.alu_data2  = data2_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_result = result_q;
    assign bus.out_rd     = rd_q;
    assign bus.out_wr_en  = wr_en_q;
    assign bus.out_z      = z_q;
    assign bus.out_err    = err_q;

`ifdef ALU_SEQ_STATS_EN
    logic [31:0] stat_ops_q;
    logic [31:0] stat_illegal_q;

    // Count handshaken responses, and separately the illegal ones; both wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_ops_q     <= 32'd0;
            stat_illegal_q <= 32'd0;
        end else if (valid_q && bus.out_ready) begin
            stat_ops_q     <= stat_ops_q + 32'd1;
            stat_illegal_q <= stat_illegal_q + {31'd0, err_q};
        end else begin
            stat_ops_q     <= stat_ops_q;
            stat_illegal_q <= stat_illegal_q;
        end
    end

    assign stat_ops     = stat_ops_q;
    assign stat_illegal = stat_illegal_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table-driven directed test of alu_op_sequencer with a
// behavioural ALU model, plus hand sequences for reset mid-EXEC and a stalled response.
module tb_alu_op_sequencer;
    localparam int BW = 64;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   exp_ops;
    int   exp_ill;

    alu_seq_if #(.BITSIZE(BW)) bus ();

`ifdef ALU_SEQ_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_illegal;
    alu_op_sequencer #(.BITSIZE(BW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .stat_ops(stat_ops), .stat_illegal(stat_illegal)
    );
`else
    alu_op_sequencer #(.BITSIZE(BW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
`endif

    // Reference ALU (combinational); alu_zero is 1 when the result is non-zero.
    logic [BW-1:0] alu_res_s;
    always_comb begin
        case (bus.alu_opcode)
            3'b000:  alu_res_s = bus.alu_data1 & bus.alu_data2;
            3'b001:  alu_res_s = bus.alu_data1 | bus.alu_data2;
            3'b010:  alu_res_s = ~bus.alu_data1;
            3'b011:  alu_res_s = bus.alu_data1;
            3'b100:  alu_res_s = bus.alu_data2;
            3'b101:  alu_res_s = bus.alu_data1 + bus.alu_data2;
            3'b110:  alu_res_s = bus.alu_data1 - bus.alu_data2;
            default: alu_res_s = {bus.alu_data1[BW-1:16], bus.alu_data2[15:0]};
        endcase
    end
    assign bus.alu_result = alu_res_s;
    assign bus.alu_zero   = (alu_res_s != {BW{1'b0}});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [31:0]   instr;
        logic [BW-1:0] rn;
        logic [BW-1:0] rm;
        logic [2:0]    op;
        logic [BW-1:0] d2;
        logic [BW-1:0] res;
        logic [4:0]    rd;
        logic          wr;
        logic          z;
        logic          err;
        int            stall;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        bus.instr    = v.instr;
        bus.rn_data  = v.rn;
        bus.rm_data  = v.rm;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.instr    = 32'h0;
        bus.rn_data  = {BW{1'b0}};
        bus.rm_data  = {BW{1'b0}};
        lat = 1;
        if (!v.err) begin
            chk({v.name, ".opcode"}, {61'd0, bus.alu_opcode}, {61'd0, v.op});
            chk({v.name, ".data1"}, bus.alu_data1, v.rn);
            chk({v.name, ".data2"}, bus.alu_data2, v.d2);
        end
        while (!bus.out_valid && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({v.name, ".latency"}, BW'(lat), v.err ? 64'd1 : 64'd2);
        chk({v.name, ".result"}, bus.out_result, v.res);
        chk({v.name, ".rd"}, {59'd0, bus.out_rd}, {59'd0, v.rd});
        chk({v.name, ".wr_en"}, {63'd0, bus.out_wr_en}, {63'd0, v.wr});
        chk({v.name, ".z"}, {63'd0, bus.out_z}, {63'd0, v.z});
        chk({v.name, ".err"}, {63'd0, bus.out_err}, {63'd0, v.err});
        // hold out_ready low; try to inject a new instruction, which must be ignored
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            bus.instr    = 32'hFFFF_FFFF;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk({v.name, ".hold_valid"}, {63'd0, bus.out_valid}, 64'd1);
            chk({v.name, ".hold_result"}, bus.out_result, v.res);
            chk({v.name, ".hold_z"}, {63'd0, bus.out_z}, {63'd0, v.z});
            chk({v.name, ".hold_ready"}, {63'd0, bus.in_ready}, 64'd0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({v.name, ".drop_valid"}, {63'd0, bus.out_valid}, 64'd0);
        chk({v.name, ".in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        exp_ops++;
        if (v.err) exp_ill++;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        checks   = 0;
        errors   = 0;
        exp_ops  = 0;
        exp_ill  = 0;
        //           name      instr                                                  rn                       rm         op      d2                  res                     rd    wr    z     err  stall
        vecs[0]  = '{"add",    {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd3},             64'd5,                   64'd7,     3'b101, 64'd7,              64'd12,                 5'd3, 1'b1, 1'b0, 1'b0, 0};
        vecs[1]  = '{"subi",   {10'b1101000100, 12'd9, 5'd4, 5'd4},                   64'd9,                   64'd0,     3'b110, 64'd9,              64'd0,                  5'd4, 1'b1, 1'b1, 1'b0, 4};
        vecs[2]  = '{"movk",   {9'b111100101, 2'b00, 16'hBEEF, 5'd2},                 64'h1234_5678_9ABC_0000, 64'd0,     3'b111, 64'hBEEF,           64'h1234_5678_9ABC_BEEF, 5'd2, 1'b1, 1'b0, 1'b0, 0};
        vecs[3]  = '{"cbz0",   {8'b10110100, 19'd4, 5'd7},                            64'd0,                   64'd0,     3'b011, 64'd0,              64'd0,                  5'd7, 1'b0, 1'b1, 1'b0, 0};
        vecs[4]  = '{"cbz1",   {8'b10110100, 19'd4, 5'd7},                            64'd1,                   64'd0,     3'b011, 64'd0,              64'd1,                  5'd7, 1'b0, 1'b0, 1'b0, 0};
        vecs[5]  = '{"illegal",32'hFFFF_FFFF,                                         64'd3,                   64'd4,     3'b000, 64'd0,              64'd0,                  5'd31, 1'b0, 1'b0, 1'b1, 0};
        vecs[6]  = '{"and",    {11'b10001010000, 5'd2, 6'd0, 5'd1, 5'd6},             64'hF0F0,                64'hFF00,  3'b000, 64'hFF00,           64'hF000,               5'd6, 1'b1, 1'b0, 1'b0, 0};
        vecs[7]  = '{"orr",    {11'b10101010000, 5'd2, 6'd0, 5'd1, 5'd8},             64'h0F,                  64'hF0,    3'b001, 64'hF0,             64'hFF,                 5'd8, 1'b1, 1'b0, 1'b0, 0};
        vecs[8]  = '{"sub",    {11'b11001011000, 5'd2, 6'd0, 5'd1, 5'd9},             64'd3,                   64'd5,     3'b110, 64'd5,              64'hFFFF_FFFF_FFFF_FFFE, 5'd9, 1'b1, 1'b0, 1'b0, 0};
        vecs[9]  = '{"addi_xzr",{10'b1001000100, 12'hFFF, 5'd1, 5'd31},               64'd1,                   64'd0,     3'b101, 64'hFFF,            64'h1000,               5'd31, 1'b0, 1'b0, 1'b0, 0};
        vecs[10] = '{"add_wrap",{11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd10},           64'hFFFF_FFFF_FFFF_FFFF, 64'd1,     3'b101, 64'd1,              64'd0,                  5'd10, 1'b1, 1'b1, 1'b0, 0};
        vecs[11] = '{"movz",   {9'b110100101, 2'b00, 16'h0042, 5'd5},                 64'hDEAD,                64'd0,     3'b100, 64'h42,             64'h42,                 5'd5, 1'b1, 1'b0, 1'b0, 0};
        vecs[12] = '{"movz_hw",{9'b110100101, 2'b01, 16'h0001, 5'd5},                 64'd0,                   64'd0,     3'b000, 64'd0,              64'd0,                  5'd5, 1'b0, 1'b0, 1'b1, 0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.instr     = 32'h0;
        bus.rn_data   = {BW{1'b0}};
        bus.rm_data   = {BW{1'b0}};
        reset_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst.out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst.out_result", bus.out_result, 64'd0);
        chk("rst.out_rd_wr_z_err", {59'd0, bus.out_rd, bus.out_wr_en, bus.out_z, bus.out_err}, 64'd0);
        chk("rst.alu_opcode", {61'd0, bus.alu_opcode}, 64'd3);
        chk("rst.alu_data", bus.alu_data1 | bus.alu_data2, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // reset while an ADD sits in EXEC: the op must vanish without a response
        @(negedge clk);
        bus.instr    = vecs[0].instr;
        bus.rn_data  = 64'd5;
        bus.rm_data  = 64'd7;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("midrst.busy", {63'd0, bus.in_ready}, 64'd0);
        reset_n = 1'b0;
        #1;
        chk("midrst.out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst.in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        chk("midrst.no_response", BW'(seen), 64'd0);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
        end

`ifdef ALU_SEQ_STATS_EN
        chk("stat_ops", {32'd0, stat_ops}, BW'(exp_ops));
        chk("stat_illegal", {32'd0, stat_illegal}, BW'(exp_ill));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
